// File: rtl/sdet_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : sdet_serializer
//  Purpose  : Parallel-to-serial front end for the bit-serial sequence
//             detector. Accepts WIDTH-bit words on a valid/ready handshake
//             and emits one bit per clock. A hold register behind the shift
//             register keeps back-to-back words gap-free.
//  Revision : 1.0  initial release
// ============================================================================
module sdet_serializer #(
  parameter int WIDTH     = 8,   // bits per word, 2..32
  parameter bit LSB_FIRST = 1'b0, // 1: din[0] leaves first
  parameter bit IDLE_BIT  = 1'b0  // serial level while no data bit is shown
) (
  input  logic             ck,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  output logic             o_bit_out,
  output logic             o_bit_valid,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sh_shifted;

  // Ready drops during reset and whenever a word is already waiting in hold.
  assign o_din_ready = !reset && !r_hold_full;
  assign w_accept    = i_din_valid && o_din_ready;
  assign w_last      = (r_cnt == C_LAST);

  // Shift one place toward the output end, filling with zero.
  assign w_sh_shifted = LSB_FIRST ? (r_sh >> 1) : (r_sh << 1);

  // Serial outputs are decoded straight from registered state.
  assign o_bit_valid = (r_state == S_SHIFT);
  assign o_bit_out   = o_bit_valid ? (LSB_FIRST ? r_sh[0] : r_sh[WIDTH-1]) : IDLE_BIT;
  assign o_busy      = o_bit_valid || r_hold_full;

  // State register: reset discards any partial or held word.
  always_ff @(posedge ck) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Next-state: route accepted words to sh or hold, and chain words on the
  // last bit so consecutive words leave without a bubble.
  always_comb begin
    w_state_nxt     = r_state;
    w_sh_nxt        = r_sh;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sh_nxt    = i_din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!w_last) begin
          w_sh_nxt  = w_sh_shifted;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_accept) begin
            w_hold_nxt      = i_din;
            w_hold_full_nxt = 1'b1;
          end
        end else if (r_hold_full) begin
          // Ready is low while hold is full, so no accept can collide here.
          w_sh_nxt        = r_hold;
          w_hold_full_nxt = 1'b0;
          w_cnt_nxt       = '0;
        end else if (w_accept) begin
          w_sh_nxt  = i_din;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
